// File: rtl/cdc_rx_byte_packer.sv
// Packs CDC-received bytes LSB-first into 32-bit words and queues them in a DEPTH-word FIFO.
// Push-to-out_vld latency 1 edge; in_ack drops only when the FIFO is full (no same-cycle pop look-ahead).
module cdc_rx_byte_packer #(
  parameter int DEPTH = 4
) (
  input  logic                     dst_clk,
  input  logic                     dst_rst_n,
  input  logic                     in_vld,
  input  logic [7:0]               in_data,
  output logic                     in_ack,
  input  logic                     flush,
  output logic                     out_vld,
  output logic [31:0]              out_data,
  output logic [3:0]               out_be,
  input  logic                     out_rdy,
  output logic [$clog2(DEPTH):0]   out_cnt,
  output logic                     ovf_err,
  input  logic                     err_clr
);

  localparam int AW = $clog2(DEPTH);

  logic [1:0]    idx_q, idx_d;
  logic [31:0]   acc_data_q, acc_data_d;
  logic [3:0]    acc_be_q, acc_be_d;
  logic [31:0]   mem_data_q [DEPTH];
  logic [31:0]   mem_data_d [DEPTH];
  logic [3:0]    mem_be_q [DEPTH];
  logic [3:0]    mem_be_d [DEPTH];
  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic          ovf_q, ovf_d;

  logic          full;
  logic          acc;
  logic          flush_go;
  logic          push;
  logic          pop;
  logic [31:0]   push_data;
  logic [3:0]    push_be;

  // Packer: a 4th byte completes a word; flush yields to an accepted byte.
  always_comb begin
    full       = (cnt_q == (AW+1)'(DEPTH));
    acc        = in_vld && !full;
    flush_go   = flush && (idx_q != 2'd0) && !acc && !full;
    pop        = (cnt_q != '0) && out_rdy;
    idx_d      = idx_q;
    acc_data_d = acc_data_q;
    acc_be_d   = acc_be_q;
    push       = 1'b0;
    push_data  = acc_data_q;
    push_be    = acc_be_q;
    if (acc) begin
      if (idx_q == 2'd3) begin
        push       = 1'b1;
        push_data  = {in_data, acc_data_q[23:0]};
        push_be    = 4'hF;
        idx_d      = 2'd0;
        acc_data_d = '0;
        acc_be_d   = '0;
      end else begin
        acc_data_d[{idx_q, 3'b000} +: 8] = in_data;
        acc_be_d[idx_q]                  = 1'b1;
        idx_d                            = idx_q + 2'd1;
      end
    end else if (flush_go) begin
      push       = 1'b1;
      idx_d      = 2'd0;
      acc_data_d = '0;
      acc_be_d   = '0;
    end
  end

  always_comb begin
    mem_data_d = mem_data_q;
    mem_be_d   = mem_be_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    if (push) begin
      mem_data_d[wr_ptr_q] = push_data;
      mem_be_d[wr_ptr_q]   = push_be;
      wr_ptr_d             = wr_ptr_q + AW'(1);
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + AW'(1);
    end
    if (push && !pop) begin
      cnt_d = cnt_q + (AW+1)'(1);
    end else if (pop && !push) begin
      cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  // A new drop outranks a concurrent clear so no overflow goes unreported.
  always_comb begin
    ovf_d = ovf_q;
    if (err_clr) begin
      ovf_d = 1'b0;
    end
    if (in_vld && full) begin
      ovf_d = 1'b1;
    end
  end

  always_ff @(posedge dst_clk or negedge dst_rst_n) begin
    if (!dst_rst_n) begin
      idx_q      <= '0;
      acc_data_q <= '0;
      acc_be_q   <= '0;
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      ovf_q      <= 1'b0;
      for (int i = 0; i < DEPTH; i++) begin
        mem_data_q[i] <= '0;
        mem_be_q[i]   <= '0;
      end
    end else begin
      idx_q      <= idx_d;
      acc_data_q <= acc_data_d;
      acc_be_q   <= acc_be_d;
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      ovf_q      <= ovf_d;
      mem_data_q <= mem_data_d;
      mem_be_q   <= mem_be_d;
    end
  end

  assign in_ack   = !full;
  assign out_vld  = (cnt_q != '0);
  assign out_data = mem_data_q[rd_ptr_q];
  assign out_be   = mem_be_q[rd_ptr_q];
  assign out_cnt  = cnt_q;
  assign ovf_err  = ovf_q;

endmodule

// File: doc/cdc_rx_byte_packer.md
# cdc_rx_byte_packer

Destination-domain consumer for the 8-bit handshake CDC receiver. It takes one-cycle byte-valid pulses with data and returns a level acknowledge that tells the receiver whether a byte can be taken. Accepted bytes are packed LSB-first into 32-bit words, which go into a small FIFO with a valid/ready output towards the dst-domain bus. It also supports partial-word flush and a sticky overflow flag.

## Interface
- DEPTH, 4, output FIFO depth in words; power of two, ≥2.
- dst_clk  in  1  destination clock; all logic is on its rising edge.
- dst_rst_n  in  1  reset, asynchronous, active-low.
- in_vld  in  1  one-cycle byte-valid pulse from the CDC receiver.
- in_data  in  8  byte, qualified by in_vld.
- in_ack  out  1  level; high means a byte presented this cycle is accepted.
- flush  in  1  level request to emit the current partial word.
- out_vld  out  1  FIFO head valid.
- out_data  out  32  FIFO head word.
- out_be  out  4  FIFO head byte enables; bit i covers out_data[8i+7:8i].
- out_rdy  in  1  downstream ready.
- out_cnt  out  log2(DEPTH)+1  words held in the FIFO.
- ovf_err  out  1  sticky: a byte arrived while in_ack was low.
- err_clr  in  1  clears ovf_err.

## Operation
- **Accept:** acc = in_vld && in_ack. in_ack = (out_cnt != DEPTH), from registered state only. No look-ahead on a same-cycle pop.
- **Packer state:** lane index idx (0..3), accumulator acc_data[31:0], acc_be[3:0]. States are EMPTY (idx=0) and PARTIAL (idx=1..3).
- **Normal byte (idx<3):**
  - on acc, in_data is written to lane idx and acc_be[idx] is set;
  - idx increments.
- **4th byte (idx==3):**
  - on acc, the word {in_data, acc_data[23:0]} is pushed with be 4'b1111;
  - the accumulator clears and idx returns to 0.
- **Flush:**
  - executes when flush=1 AND idx!=0 AND no acc this cycle AND FIFO not full;
  - pushes acc_data with acc_be (low lanes contiguous, e.g. 4'b0011), unused lanes 0;
  - clears the accumulator and sets idx=0.
- **Flush held off:**
  - flush with idx==0 is a no-op;
  - flush in the same cycle as acc is deferred: acc wins, and flush takes effect in a later cycle if still asserted.
- **FIFO:**
  - push as above; pop = out_vld && out_rdy;
  - push and pop in the same cycle leave out_cnt unchanged;
  - pointers wrap modulo DEPTH;
  - out_vld = (out_cnt != 0); out_data/out_be are driven from the head entry.
- **Overflow:** in_vld && !in_ack sets ovf_err. The byte is dropped and the packer is unchanged. If err_clr and a set condition occur in the same cycle, set wins.
- **Reset:**
  - in_ack=1, out_vld=0, out_data=0, out_be=0, out_cnt=0, ovf_err=0;
  - idx=0, accumulator 0, FIFO storage 0.
- **Reset mid-packet:** the partial word and all queued words are discarded. There is no recovery beyond reset.

## Timing
- A push at edge N gives out_vld=1 and the new out_cnt from edge N onward. The 4th byte to out_vld latency is 1 edge.
- A pop at edge N makes the next entry visible after N. When the FIFO was full, in_ack rises after N, so a byte in the same cycle as the freeing pop is refused.
- in_ack has no combinational path from in_vld, in_data, out_rdy, or flush.
- Back-to-back in_vld pulses on consecutive cycles are accepted while in_ack=1. There is no minimum gap.
- out_data/out_be are held stable while out_vld && !out_rdy.

## Test plan
- **Full word:** after reset, bytes 0x11,0x22,0x33,0x44 -> one word 0x44332211, be 4'hF, out_vld high the cycle after the 4th accept, out_cnt=1.
- **Partial flush:** bytes 0xAA,0xBB, then flush for 1 cycle -> word 0x0000BBAA, be 4'b0011. flush with idx==0 -> no push.
- **Flush deferred:** flush asserted in the same cycle as the 3rd byte -> no push that cycle. The next cycle, with flush still high, pushes 3 bytes with be 4'b0111.
- **Full FIFO:** DEPTH=4, out_rdy=0, 16 bytes -> out_cnt=4, in_ack=0. A 17th byte -> dropped, ovf_err=1. One pop -> in_ack=1 on the next cycle. err_clr -> ovf_err=0. err_clr concurrent with a dropped byte -> ovf_err stays 1.
- **Pointer wrap / streaming:** 40 bytes of an incrementing pattern with random out_rdy -> 10 words, in order and bit-exact, no loss while in_ack is honoured. Simultaneous push/pop keeps out_cnt steady.
- **Reset mid-operation:** assert dst_rst_n low with 2 words queued and idx=2 -> all outputs return to reset values immediately. The next 4 bytes form a clean word with be 4'hF.
